// File: rtl/pkg_ticks.sv
// Shared constants, state encodings and the configuration payload for the
// tick controller.
package pkg_ticks;

  localparam int unsigned LARGURA_DIV    = 21;
  localparam int unsigned NUM_CANAIS     = 4;
  localparam int unsigned LARGURA_CONT   = 8;
  localparam int unsigned ATRASO_PARTIDA = 3;
  localparam int unsigned LARGURA_CANAL  = $clog2(NUM_CANAIS);
  localparam int unsigned LARGURA_TAP    = $clog2(LARGURA_DIV);

  typedef enum logic {OCIOSO = 1'b0, APLICANDO = 1'b1} estado_cfg_t;
  typedef enum logic {DESLIGADO = 1'b0, CONTANDO = 1'b1} estado_canal_t;
  typedef enum logic {PERIODICO = 1'b0, UNICO = 1'b1} modo_t;

  // Latched configuration request.
  typedef struct packed {
    logic [LARGURA_CANAL-1:0] canal;
    logic [LARGURA_TAP-1:0]   tap;
    logic [LARGURA_CONT-1:0]  periodo;
    modo_t                    modo;
    logic                     ativar;
  } cfg_t;

  // Deactivation is always accepted; activation needs a real tap and a
  // non-zero period.
  function automatic logic cfg_invalida(cfg_t c);
    return c.ativar && ((c.tap >= LARGURA_TAP'(LARGURA_DIV)) ||
                        (c.periodo == '0));
  endfunction

endpackage

// File: rtl/sincronizador_borda.sv
// Two-flop synchronizer + edge register for asynchronous divider taps.
// Ports: clk, rst_n (async, active low), dado_i (asynchronous taps),
//        borda_o (registered one-cycle rising-edge flags).
// Edges are held off for ATRASO_PARTIDA clocks after reset release.
module sincronizador_borda
  import pkg_ticks::*;
#(
  parameter int unsigned LARGURA = LARGURA_DIV
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [LARGURA-1:0] dado_i,
  output logic [LARGURA-1:0] borda_o
);

  localparam int unsigned LARGURA_ATRASO = $clog2(ATRASO_PARTIDA + 1);

  logic [LARGURA-1:0]        s1_q, s2_q, prev_q, borda_q;
  logic [LARGURA_ATRASO-1:0] atraso_q;
  logic                      liberado;

  assign liberado = (atraso_q == LARGURA_ATRASO'(ATRASO_PARTIDA));
  assign borda_o  = borda_q;

  // Sync chain, previous-value register and startup hold-off counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= '0;
      s2_q     <= '0;
      prev_q   <= '0;
      borda_q  <= '0;
      atraso_q <= '0;
    end else begin
      s1_q    <= dado_i;
      s2_q    <= s1_q;
      prev_q  <= s2_q;
      borda_q <= liberado ? (s2_q & ~prev_q) : '0;
      if (!liberado) atraso_q <= atraso_q + 1'b1;
    end
  end

endmodule

// File: rtl/controlador_ticks.sv
// Converts ripple-divider taps into single-cycle tick enables in the
// clock_in domain, with NUM_CANAIS independently configured channels.
// Ports: clock_in, reset_n (async, active low), divisor_taps (async taps),
//        cfg_valid/cfg_ready handshake with cfg_canal, cfg_tap, cfg_periodo,
//        cfg_modo, cfg_ativar; tick/ocupado per channel; erro_cfg pulse.
module controlador_ticks
  import pkg_ticks::*;
(
  input  logic                     clock_in,
  input  logic                     reset_n,
  input  logic [LARGURA_DIV-1:0]   divisor_taps,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [LARGURA_CANAL-1:0] cfg_canal,
  input  logic [LARGURA_TAP-1:0]   cfg_tap,
  input  logic [LARGURA_CONT-1:0]  cfg_periodo,
  input  logic                     cfg_modo,
  input  logic                     cfg_ativar,
  output logic [NUM_CANAIS-1:0]    tick,
  output logic [NUM_CANAIS-1:0]    ocupado,
  output logic                     erro_cfg
);

  logic [LARGURA_DIV-1:0] borda;

  sincronizador_borda #(.LARGURA(LARGURA_DIV)) u_sinc (
    .clk     (clock_in),
    .rst_n   (reset_n),
    .dado_i  (divisor_taps),
    .borda_o (borda)
  );

  // Configuration port: accept in OCIOSO, validate and write in APLICANDO.
  estado_cfg_t estado_q, estado_d;
  cfg_t        cfg_q, cfg_d;
  logic        erro_q, erro_d;
  logic        escrita;

  always_comb begin
    estado_d = estado_q;
    cfg_d    = cfg_q;
    erro_d   = 1'b0;
    escrita  = 1'b0;
    unique case (estado_q)
      OCIOSO: begin
        if (cfg_valid) begin
          cfg_d.canal   = cfg_canal;
          cfg_d.tap     = cfg_tap;
          cfg_d.periodo = cfg_periodo;
          cfg_d.modo    = modo_t'(cfg_modo);
          cfg_d.ativar  = cfg_ativar;
          estado_d      = APLICANDO;
        end
      end
      APLICANDO: begin
        erro_d   = cfg_invalida(cfg_q);
        escrita  = ~cfg_invalida(cfg_q);
        estado_d = OCIOSO;
      end
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      estado_q <= OCIOSO;
      cfg_q    <= '0;
      erro_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cfg_q    <= cfg_d;
      erro_q   <= erro_d;
    end
  end

  assign cfg_ready = (estado_q == OCIOSO);
  assign erro_cfg  = erro_q;

  // One down-counting channel per tick output.
  for (genvar c = 0; c < NUM_CANAIS; c++) begin : g_canal
    estado_canal_t           est_q, est_d;
    logic [LARGURA_TAP-1:0]  tap_q, tap_d;
    modo_t                   modo_q, modo_d;
    logic [LARGURA_CONT-1:0] per_q, per_d, cont_q, cont_d;
    logic                    tick_q, tick_d;
    logic                    alvo;

    assign alvo = escrita && (cfg_q.canal == LARGURA_CANAL'(c));

    // A write to this channel takes priority over a same-cycle tap edge.
    always_comb begin
      est_d  = est_q;
      tap_d  = tap_q;
      modo_d = modo_q;
      per_d  = per_q;
      cont_d = cont_q;
      tick_d = 1'b0;
      if (alvo) begin
        if (cfg_q.ativar) begin
          est_d  = CONTANDO;
          tap_d  = cfg_q.tap;
          modo_d = cfg_q.modo;
          per_d  = cfg_q.periodo;
          cont_d = cfg_q.periodo;
        end else begin
          est_d  = DESLIGADO;
          cont_d = '0;
        end
      end else if ((est_q == CONTANDO) && borda[tap_q]) begin
        if (cont_q == LARGURA_CONT'(1)) begin
          tick_d = 1'b1;
          if (modo_q == UNICO) begin
            est_d  = DESLIGADO;
            cont_d = '0;
          end else begin
            cont_d = per_q;
          end
        end else begin
          cont_d = cont_q - 1'b1;
        end
      end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
        est_q  <= DESLIGADO;
        tap_q  <= '0;
        modo_q <= PERIODICO;
        per_q  <= '0;
        cont_q <= '0;
        tick_q <= 1'b0;
      end else begin
        est_q  <= est_d;
        tap_q  <= tap_d;
        modo_q <= modo_d;
        per_q  <= per_d;
        cont_q <= cont_d;
        tick_q <= tick_d;
      end
    end

    assign tick[c]    = tick_q;
    assign ocupado[c] = (est_q == CONTANDO);
  end

endmodule

// File: tb/tb_controlador_ticks.sv
// Randomized self-checking bench for controlador_ticks against a
// transaction-level model of the channels.
module tb_controlador_ticks;
  import pkg_ticks::*;

  logic                     clock_in = 1'b0;
  logic                     reset_n  = 1'b1;
  logic [LARGURA_DIV-1:0]   divisor_taps;
  logic                     cfg_valid;
  logic                     cfg_ready;
  logic [LARGURA_CANAL-1:0] cfg_canal;
  logic [LARGURA_TAP-1:0]   cfg_tap;
  logic [LARGURA_CONT-1:0]  cfg_periodo;
  logic                     cfg_modo;
  logic                     cfg_ativar;
  logic [NUM_CANAIS-1:0]    tick;
  logic [NUM_CANAIS-1:0]    ocupado;
  logic                     erro_cfg;

  controlador_ticks dut (
    .clock_in     (clock_in),
    .reset_n      (reset_n),
    .divisor_taps (divisor_taps),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_canal    (cfg_canal),
    .cfg_tap      (cfg_tap),
    .cfg_periodo  (cfg_periodo),
    .cfg_modo     (cfg_modo),
    .cfg_ativar   (cfg_ativar),
    .tick         (tick),
    .ocupado      (ocupado),
    .erro_cfg     (erro_cfg)
  );

  always #5 clock_in = ~clock_in;

  int n_ok  = 0;
  int n_tot = 0;

  task automatic verificar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_tot++;
    if (obs === esp) n_ok++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, esp, $time);
  endtask

  // Free-running divider: tap i toggles every 2^i clocks.
  logic [31:0] div_cnt;

  // Reference model state.
  logic [LARGURA_DIV-1:0] hist [0:4];   // hist[j] = taps seen at edge n-j
  int                     n_borda;      // edges since reset release
  bit                     m_ativo [NUM_CANAIS];
  bit                     m_unico [NUM_CANAIS];
  int                     m_tap   [NUM_CANAIS];
  int                     m_per   [NUM_CANAIS];
  int                     m_rest  [NUM_CANAIS];
  bit                     m_pend;
  int                     p_canal, p_tap, p_per;
  bit                     p_modo, p_ativar;
  logic [NUM_CANAIS-1:0]  e_tick, e_ocup;
  bit                     e_erro, e_ready;

  int  cyc = 0;
  bit  mede = 0;
  int  ult0 = 0;
  int  cont1 = 0;

  task automatic modelo_reset();
    n_borda = 0;
    for (int j = 0; j < 5; j++) hist[j] = '0;
    m_pend = 0;
    for (int ch = 0; ch < NUM_CANAIS; ch++) m_ativo[ch] = 0;
    e_tick = '0;
    e_ocup = '0;
    e_erro = 0;
    e_ready = 1;
  endtask

  // Advance the model by one clock edge given the inputs present at it.
  task automatic modelo_borda(input logic [LARGURA_DIV-1:0] taps_s, input bit v_s,
                              input int canal_s, input int tap_s, input int per_s,
                              input bit modo_s, input bit ativar_s);
    logic [LARGURA_DIV-1:0] r;
    int alvo;
    n_borda++;
    for (int j = 4; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = taps_s;
    // A tap that first reads 1 at edge k is counted at edge k+3; nothing
    // registered in the first three edges after release counts.
    r = (n_borda >= 5) ? (hist[3] & ~hist[4]) : '0;
    e_tick = '0;
    e_erro = 0;
    alvo = -1;
    if (m_pend) begin
      m_pend = 0;
      e_ready = 1;
      if (p_ativar && (p_tap >= 21 || p_per == 0)) e_erro = 1;
      else begin
        alvo = p_canal;
        m_ativo[alvo] = p_ativar;
        if (p_ativar) begin
          m_tap[alvo] = p_tap;
          m_unico[alvo] = p_modo;
          m_per[alvo] = p_per;
          m_rest[alvo] = p_per;
        end
      end
    end else if (v_s) begin
      m_pend = 1;
      e_ready = 0;
      p_canal = canal_s; p_tap = tap_s; p_per = per_s; p_modo = modo_s; p_ativar = ativar_s;
    end
    for (int ch = 0; ch < NUM_CANAIS; ch++) begin
      if (ch != alvo && m_ativo[ch] && r[5'(m_tap[ch])]) begin
        if (m_rest[ch] == 1) begin
          e_tick[2'(ch)] = 1'b1;
          if (m_unico[ch]) m_ativo[ch] = 0;
          else m_rest[ch] = m_per[ch];
        end else m_rest[ch] = m_rest[ch] - 1;
      end
    end
    for (int ch = 0; ch < NUM_CANAIS; ch++) e_ocup[2'(ch)] = m_ativo[ch];
  endtask

  // One clock: sample inputs at the edge, update model, check, drive next.
  task automatic passo();
    logic [LARGURA_DIV-1:0] ts;
    bit v, m, a;
    int c, t, p;
    @(posedge clock_in);
    ts = divisor_taps; v = cfg_valid; c = int'(cfg_canal); t = int'(cfg_tap);
    p = int'(cfg_periodo); m = cfg_modo; a = cfg_ativar;
    #1;
    cyc++;
    if (reset_n) modelo_borda(ts, v, c, t, p, m, a);
    verificar("tick", 32'(tick), 32'(e_tick));
    verificar("ocupado", 32'(ocupado), 32'(e_ocup));
    verificar("erro_cfg", 32'(erro_cfg), 32'(e_erro));
    verificar("cfg_ready", 32'(cfg_ready), 32'(e_ready));
    if (mede) begin
      if (tick[0]) begin
        if (ult0 != 0) verificar("periodo_ch0", 32'(cyc - ult0), 32'd64);
        ult0 = cyc;
      end
      if (tick[1]) cont1++;
    end
    div_cnt = div_cnt + 1;
    divisor_taps = div_cnt[LARGURA_DIV-1:0];
    cfg_valid = 1'b0;
  endtask

  task automatic rodar(input int n);
    for (int i = 0; i < n; i++) passo();
  endtask

  task automatic configurar(input int canal, input int tap, input int per,
                            input bit modo, input bit ativar);
    for (int i = 0; i < 4 && !e_ready; i++) passo();
    cfg_canal = 2'(canal); cfg_tap = 5'(tap); cfg_periodo = 8'(per);
    cfg_modo = modo; cfg_ativar = ativar; cfg_valid = 1'b1;
    passo();
  endtask

  initial begin
    cfg_valid = 0; cfg_canal = '0; cfg_tap = '0; cfg_periodo = '0;
    cfg_modo = 0; cfg_ativar = 0;
    div_cnt = $urandom;
    divisor_taps = div_cnt[LARGURA_DIV-1:0];
    modelo_reset();
    #1 reset_n = 1'b0;
    #1;
    verificar("reset_tick", 32'(tick), 32'd0);
    verificar("reset_ready", 32'(cfg_ready), 32'd1);
    rodar(3);
    reset_n = 1'b1;

    // Startup with live taps, then periodic ch0 and one-shot ch1.
    rodar(5);
    configurar(0, 3, 4, 0, 1);
    mede = 1;
    configurar(1, 0, 1, 1, 1);
    rodar(300);
    mede = 0;
    verificar("ch1_unico_count", 32'(cont1), 32'd1);

    // Invalid requests leave the channel alone.
    configurar(2, 21, 5, 0, 1);
    configurar(2, 4, 0, 0, 1);
    rodar(6);

    // Rewrites straddling both parities of tap 0 edges, then a stop.
    configurar(0, 0, 5, 0, 1);
    rodar(7);
    configurar(0, 0, 3, 0, 1);
    passo();
    configurar(0, 0, 3, 0, 1);
    rodar(20);
    configurar(0, 0, 0, 0, 0);
    rodar(40);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if (e_ready && $urandom_range(0, 24) == 0) begin
        cfg_canal = 2'($urandom_range(0, 3));
        cfg_tap = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(21, 31))
                                              : 5'($urandom_range(0, 4));
        cfg_periodo = 8'($urandom_range(0, 6));
        cfg_modo = 1'($urandom_range(0, 1));
        cfg_ativar = ($urandom_range(0, 6) != 0);
        cfg_valid = 1'b1;
      end
      passo();
    end

    // Reset in the middle of counting on two channels.
    configurar(0, 0, 2, 0, 1);
    configurar(1, 1, 3, 0, 1);
    rodar(10);
    #2 reset_n = 1'b0;
    #1;
    verificar("rst_async_tick", 32'(tick), 32'd0);
    verificar("rst_async_ocupado", 32'(ocupado), 32'd0);
    modelo_reset();
    rodar(2);
    reset_n = 1'b1;
    rodar(200);

    $display("%0d/%0d checks passed", n_ok, n_tot);
    $finish;
  end

endmodule
